// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// FSM states and the instruction-class decode used by next-state and output logic.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011, OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110, OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000, OP_NOT  = 5'b10001, OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011, OP_IN   = 5'b10101, OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111, OP_MFLO = 5'b11000, OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_INCPC = 5'b11111;

    typedef enum logic [3:0] {
        S_IDLE, S_HALT, S_FETCH0, S_FETCH1, S_FETCH1W, S_FETCH2, S_DECODE,
        S_T3, S_T4, S_T5, S_T6, S_T7
    } state_e;

    typedef enum logic [3:0] {
        CL_RR, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_ST, CL_BR, CL_JR,
        CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
    } class_e;

    function automatic class_e op_class(input logic [4:0] op);
        if (op >= OP_ADD && op <= OP_ROL) return CL_RR;
        if (op == OP_LDI || (op >= OP_ADDI && op <= OP_ORI)) return CL_IMM;
        case (op)
            OP_LD:           return CL_LD;
            OP_ST:           return CL_ST;
            OP_MUL, OP_DIV:  return CL_MULDIV;
            OP_NEG, OP_NOT:  return CL_UNARY;
            OP_BR:           return CL_BR;
            OP_JR:           return CL_JR;
            OP_IN:           return CL_IN;
            OP_OUT:          return CL_OUT;
            OP_MFHI:         return CL_MFHI;
            OP_MFLO:         return CL_MFLO;
            OP_NOP:          return CL_NOP;
            OP_HALT:         return CL_HALT;
            default:         return CL_ILL;
        endcase
    endfunction

    function automatic state_e last_step(input class_e c);
        case (c)
            CL_RR, CL_IMM:     return S_T5;
            CL_UNARY:          return S_T4;
            CL_MULDIV, CL_BR:  return S_T6;
            CL_LD, CL_ST:      return S_T7;
            default:           return S_T3;
        endcase
    endfunction

    // States that hold a RAM strobe for MEM_WAIT cycles.
    function automatic logic in_wait(input state_e s, input class_e c);
        return (s == S_FETCH1W) || (s == S_T6 && c == CL_LD) || (s == S_T7 && c == CL_ST);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter timing RAM accesses: load MEM_WAIT-1 on entry, decrement, done at zero.
module mem_wait_counter #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int unsigned W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = W'(MEM_WAIT - 1);
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control FSM for the bus-based CPU datapath: fetch, decode on
// IR[31:27] and per-T-step bus source / load strobes.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stop,
    input  logic [31:0] IR_out,
    input  logic        CON_out,
    output logic        G_ra,
    output logic        G_rb,
    output logic        G_rc,
    output logic        R_in,
    output logic        R_out,
    output logic        BA_out,
    output logic        CON_en,
    output logic        HI_en,
    output logic        LO_en,
    output logic        Zhi_en,
    output logic        Zlo_en,
    output logic        PC_en,
    output logic        MDR_en,
    output logic        InPort_en,
    output logic        C_en,
    output logic        HI_write_enable,
    output logic        LO_write_enable,
    output logic        Z_write_enable,
    output logic        PC_write_enable,
    output logic        MDR_write_enable,
    output logic        OutPort_write_enable,
    output logic        MAR_write_enable,
    output logic        Y_write_enable,
    output logic        IR_write_enable,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [4:0]  ALU_signals,
    output logic        halted,
    output logic        illegal
);
    state_e     state_q, state_d, done_state;
    class_e     cls;
    logic [4:0] op;
    logic       wait_done, wait_load, wait_dec;
    logic       unused_ir_bits;

    assign op             = IR_out[31:27];
    assign unused_ir_bits = ^IR_out[26:0];
    assign cls            = op_class(op);
    assign done_state     = stop ? S_IDLE : S_FETCH0;
    assign wait_load      = in_wait(state_d, cls) && (state_d != state_q);
    assign wait_dec       = in_wait(state_q, cls);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .load_i (wait_load),
        .dec_i  (wait_dec),
        .done_o (wait_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (run) state_d = S_FETCH0;
            S_FETCH0:       state_d = S_FETCH1;
            S_FETCH1:       state_d = S_FETCH1W;
            S_FETCH1W:      if (wait_done) state_d = S_FETCH2;
            S_FETCH2:       state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CL_HALT:        state_d = S_HALT;
                    CL_ILL, CL_NOP: state_d = done_state;
                    default:        state_d = S_T3;
                endcase
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                // Execute T-steps are shared by all classes; the class picks the final one.
                if (in_wait(state_q, cls) && !wait_done) state_d = state_q;
                else if (state_q == last_step(cls))      state_d = done_state;
                else                                     state_d = state_e'(state_q + 4'd1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        G_ra = 1'b0; G_rb = 1'b0; G_rc = 1'b0; R_in = 1'b0; R_out = 1'b0; BA_out = 1'b0;
        CON_en = 1'b0; HI_en = 1'b0; LO_en = 1'b0; Zhi_en = 1'b0; Zlo_en = 1'b0;
        PC_en = 1'b0; MDR_en = 1'b0; InPort_en = 1'b0; C_en = 1'b0;
        HI_write_enable = 1'b0; LO_write_enable = 1'b0; Z_write_enable = 1'b0;
        PC_write_enable = 1'b0; MDR_write_enable = 1'b0; OutPort_write_enable = 1'b0;
        MAR_write_enable = 1'b0; Y_write_enable = 1'b0; IR_write_enable = 1'b0;
        mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        ALU_signals = '0; halted = 1'b0; illegal = 1'b0;
        case (state_q)
            S_HALT:    halted = 1'b1;
            S_FETCH0:  begin PC_en = 1'b1; MAR_write_enable = 1'b1; Z_write_enable = 1'b1; ALU_signals = ALU_INCPC; end
            S_FETCH1:  begin Zlo_en = 1'b1; PC_write_enable = 1'b1; end
            S_FETCH1W: begin mem_read_enable = 1'b1; MDR_write_enable = 1'b1; end
            S_FETCH2:  begin MDR_en = 1'b1; IR_write_enable = 1'b1; end
            S_DECODE:  illegal = (cls == CL_ILL);
            S_T3: begin
                case (cls)
                    CL_RR, CL_IMM: begin G_rb = 1'b1; R_out = 1'b1; Y_write_enable = 1'b1; BA_out = (op == OP_LDI); end
                    CL_UNARY:      begin G_rb = 1'b1; R_out = 1'b1; Z_write_enable = 1'b1; ALU_signals = op; end
                    CL_MULDIV:     begin G_ra = 1'b1; R_out = 1'b1; Y_write_enable = 1'b1; end
                    CL_LD, CL_ST:  begin G_rb = 1'b1; BA_out = 1'b1; R_out = 1'b1; Y_write_enable = 1'b1; end
                    CL_BR:         begin G_ra = 1'b1; R_out = 1'b1; CON_en = 1'b1; end
                    CL_JR:         begin G_ra = 1'b1; R_out = 1'b1; PC_write_enable = 1'b1; end
                    CL_IN:         begin InPort_en = 1'b1; G_ra = 1'b1; R_in = 1'b1; end
                    CL_OUT:        begin G_ra = 1'b1; R_out = 1'b1; OutPort_write_enable = 1'b1; end
                    CL_MFHI:       begin HI_en = 1'b1; G_ra = 1'b1; R_in = 1'b1; end
                    CL_MFLO:       begin LO_en = 1'b1; G_ra = 1'b1; R_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_RR:        begin G_rc = 1'b1; R_out = 1'b1; Z_write_enable = 1'b1; ALU_signals = op; end
                    CL_IMM:       begin C_en = 1'b1; Z_write_enable = 1'b1; ALU_signals = (op == OP_LDI) ? ALU_ADD : op; end
                    CL_UNARY:     begin Zlo_en = 1'b1; G_ra = 1'b1; R_in = 1'b1; end
                    CL_MULDIV:    begin G_rb = 1'b1; R_out = 1'b1; Z_write_enable = 1'b1; ALU_signals = op; end
                    CL_LD, CL_ST: begin C_en = 1'b1; Z_write_enable = 1'b1; ALU_signals = ALU_ADD; end
                    CL_BR:        begin PC_en = 1'b1; Y_write_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_RR, CL_IMM: begin Zlo_en = 1'b1; G_ra = 1'b1; R_in = 1'b1; end
                    CL_MULDIV:     begin Zlo_en = 1'b1; LO_write_enable = 1'b1; end
                    CL_LD, CL_ST:  begin Zlo_en = 1'b1; MAR_write_enable = 1'b1; end
                    CL_BR:         begin C_en = 1'b1; Z_write_enable = 1'b1; ALU_signals = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_MULDIV: begin Zhi_en = 1'b1; HI_write_enable = 1'b1; end
                    CL_LD:     begin mem_read_enable = 1'b1; MDR_write_enable = 1'b1; end
                    CL_ST:     begin G_ra = 1'b1; R_out = 1'b1; MDR_write_enable = 1'b1; end
                    CL_BR:     begin Zlo_en = CON_out; PC_write_enable = CON_out; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD:   begin MDR_en = 1'b1; G_ra = 1'b1; R_in = 1'b1; end
                    CL_ST:   mem_write_enable = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT 1 and 3) checked per cycle
// against a per-instruction strobe-sequence model built from the T-step rules.
module tb_control_sequencer;

    typedef logic [32:0] vec_t;

    localparam vec_t GRA   = 33'd1 << 32, GRB   = 33'd1 << 31, GRC   = 33'd1 << 30;
    localparam vec_t RIN   = 33'd1 << 29, ROUT  = 33'd1 << 28, BA    = 33'd1 << 27;
    localparam vec_t CONEN = 33'd1 << 26, HIEN  = 33'd1 << 25, LOEN  = 33'd1 << 24;
    localparam vec_t ZHI   = 33'd1 << 23, ZLO   = 33'd1 << 22, PCEN  = 33'd1 << 21;
    localparam vec_t MDREN = 33'd1 << 20, INP   = 33'd1 << 19, CEN   = 33'd1 << 18;
    localparam vec_t HIWE  = 33'd1 << 17, LOWE  = 33'd1 << 16, ZWE   = 33'd1 << 15;
    localparam vec_t PCWE  = 33'd1 << 14, MDRWE = 33'd1 << 13, OUTWE = 33'd1 << 12;
    localparam vec_t MARWE = 33'd1 << 11, YWE   = 33'd1 << 10, IRWE  = 33'd1 << 9;
    localparam vec_t RD    = 33'd1 << 8,  WR    = 33'd1 << 7,  HALTD = 33'd1 << 6;
    localparam vec_t ILL   = 33'd1 << 5;
    localparam logic [4:0] ADD_C = 5'b00011, INC_C = 5'b11111;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        run_s, stop_s, con_s;
    logic [1:0][31:0]  ir_s;
    logic [1:0][32:0]  ov;

    int   nvec = 0;
    int   nerr = 0;
    vec_t expq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic ra, rb, rc, rin, rout, ba, conen, hien, loen, zhi, zlo, pcen, mdren, inp, cen;
        logic hiwe, lowe, zwe, pcwe, mdrwe, outwe, marwe, ywe, irwe, rd, wr, hlt, ill;
        logic [4:0] alu;

        control_sequencer #(.MEM_WAIT(g == 0 ? 1 : 3)) dut (
            .clk(clk), .reset(reset), .run(run_s[g]), .stop(stop_s[g]),
            .IR_out(ir_s[g]), .CON_out(con_s[g]),
            .G_ra(ra), .G_rb(rb), .G_rc(rc), .R_in(rin), .R_out(rout), .BA_out(ba),
            .CON_en(conen), .HI_en(hien), .LO_en(loen), .Zhi_en(zhi), .Zlo_en(zlo),
            .PC_en(pcen), .MDR_en(mdren), .InPort_en(inp), .C_en(cen),
            .HI_write_enable(hiwe), .LO_write_enable(lowe), .Z_write_enable(zwe),
            .PC_write_enable(pcwe), .MDR_write_enable(mdrwe), .OutPort_write_enable(outwe),
            .MAR_write_enable(marwe), .Y_write_enable(ywe), .IR_write_enable(irwe),
            .mem_read_enable(rd), .mem_write_enable(wr), .ALU_signals(alu),
            .halted(hlt), .illegal(ill)
        );

        assign ov[g] = {ra, rb, rc, rin, rout, ba, conen, hien, loen, zhi, zlo, pcen, mdren, inp, cen,
                        hiwe, lowe, zwe, pcwe, mdrwe, outwe, marwe, ywe, irwe, rd, wr, hlt, ill, alu};
    end

    function automatic vec_t alu(input logic [4:0] a);
        return {28'd0, a};
    endfunction

    function automatic int unsigned mw_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Full per-cycle strobe sequence of one instruction, FETCH0 through its last step.
    function automatic void build(input logic [4:0] op, input int unsigned mw, input logic con);
        logic bad;
        bad = (op == 5'b10100) || (op > 5'b11010);
        expq.delete();
        expq.push_back(PCEN | MARWE | ZWE | alu(INC_C));
        expq.push_back(ZLO | PCWE);
        for (int unsigned i = 0; i < mw; i++) expq.push_back(RD | MDRWE);
        expq.push_back(MDREN | IRWE);
        expq.push_back(bad ? ILL : '0);
        if (op >= 5'd3 && op <= 5'd10) begin
            expq.push_back(GRB | ROUT | YWE);
            expq.push_back(GRC | ROUT | ZWE | alu(op));
            expq.push_back(ZLO | GRA | RIN);
        end else if (op == 5'd1 || (op >= 5'd11 && op <= 5'd13)) begin
            expq.push_back(GRB | ROUT | YWE | ((op == 5'd1) ? BA : '0));
            expq.push_back(CEN | ZWE | alu((op == 5'd1) ? ADD_C : op));
            expq.push_back(ZLO | GRA | RIN);
        end else begin
            case (op)
                5'd16, 5'd17: begin
                    expq.push_back(GRB | ROUT | ZWE | alu(op));
                    expq.push_back(ZLO | GRA | RIN);
                end
                5'd14, 5'd15: begin
                    expq.push_back(GRA | ROUT | YWE);
                    expq.push_back(GRB | ROUT | ZWE | alu(op));
                    expq.push_back(ZLO | LOWE);
                    expq.push_back(ZHI | HIWE);
                end
                5'd0, 5'd2: begin
                    expq.push_back(GRB | BA | ROUT | YWE);
                    expq.push_back(CEN | ZWE | alu(ADD_C));
                    expq.push_back(ZLO | MARWE);
                    if (op == 5'd0) begin
                        for (int unsigned i = 0; i < mw; i++) expq.push_back(RD | MDRWE);
                        expq.push_back(MDREN | GRA | RIN);
                    end else begin
                        expq.push_back(GRA | ROUT | MDRWE);
                        for (int unsigned i = 0; i < mw; i++) expq.push_back(WR);
                    end
                end
                5'd18: begin
                    expq.push_back(GRA | ROUT | CONEN);
                    expq.push_back(PCEN | YWE);
                    expq.push_back(CEN | ZWE | alu(ADD_C));
                    expq.push_back(con ? (ZLO | PCWE) : '0);
                end
                5'd19: expq.push_back(GRA | ROUT | PCWE);
                5'd21: expq.push_back(INP | GRA | RIN);
                5'd22: expq.push_back(GRA | ROUT | OUTWE);
                5'd23: expq.push_back(HIEN | GRA | RIN);
                5'd24: expq.push_back(LOEN | GRA | RIN);
                default: ;
            endcase
        end
    endfunction

    task automatic chk(input int k, input vec_t exp, input string tag);
        nvec++;
        if (ov[k] !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d got=%h exp=%h", tag, k, ov[k], exp);
        end
    endtask

    // Entered and left at a negedge with dut k in FETCH0.
    task automatic do_instr(input int k, input logic [4:0] op, input logic con, input logic stopv);
        run_s[k] = 1'b0;
        ir_s[k]  = {op, 27'($urandom)};
        con_s[k] = con;
        build(op, mw_of(k), con);
        for (int i = 0; i < expq.size(); i++) begin
            if (i == expq.size() - 1) stop_s[k] = stopv;
            chk(k, expq[i], $sformatf("op%02h_step%0d", op, i));
            @(negedge clk);
        end
        stop_s[k] = 1'b0;
        if (op == 5'b11010 || stopv) begin
            for (int i = 0; i < 2; i++) begin
                chk(k, (op == 5'b11010) ? HALTD : '0, (op == 5'b11010) ? "halt_hold" : "stop_idle");
                @(negedge clk);
            end
            run_s[k] = 1'b1;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [4:0] op;
        vec_t       exp;
    } tv_t;

    tv_t tbl[8];

    initial begin
        logic [4:0] rop;
        reset = 1'b0;
        run_s = '0; stop_s = '0; con_s = '0; ir_s = '0;
        tbl[0] = '{5'b00011, PCEN | MARWE | ZWE | alu(INC_C)};
        tbl[1] = '{5'b00011, ZLO | PCWE};
        tbl[2] = '{5'b00011, RD | MDRWE};
        tbl[3] = '{5'b00011, MDREN | IRWE};
        tbl[4] = '{5'b00011, '0};
        tbl[5] = '{5'b00011, GRB | ROUT | YWE};
        tbl[6] = '{5'b00011, GRC | ROUT | ZWE | alu(5'b00011)};
        tbl[7] = '{5'b00011, ZLO | GRA | RIN};

        repeat (2) @(negedge clk);
        chk(0, '0, "reset"); chk(1, '0, "reset");
        reset = 1'b1;
        @(negedge clk);
        chk(0, '0, "idle"); chk(1, '0, "idle");

        // add R1,R2,R3 on the single-cycle-memory instance
        run_s[0] = 1'b1;
        @(negedge clk);
        run_s[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ir_s[0] = {tbl[i].op, 4'd1, 4'd2, 4'd3, 15'd0};
            chk(0, tbl[i].exp, $sformatf("tbl%0d", i));
            @(negedge clk);
        end
        do_instr(0, 5'b10010, 1'b0, 1'b0);
        do_instr(0, 5'b10010, 1'b1, 1'b0);
        do_instr(0, 5'b11010, 1'b0, 1'b0);
        do_instr(0, 5'b11100, 1'b0, 1'b0);
        do_instr(0, 5'b00000, 1'b0, 1'b0);
        for (int n = 0; n < 30; n++) begin
            rop = 5'($urandom_range(0, 31));
            do_instr(0, rop, 1'($urandom), (rop != 5'b11010) && ($urandom_range(0, 7) == 0));
        end
        run_s[0] = 1'b0;

        // MEM_WAIT=3 instance
        run_s[1] = 1'b1;
        @(negedge clk);
        do_instr(1, 5'b00000, 1'b0, 1'b0);
        do_instr(1, 5'b00010, 1'b0, 1'b0);
        do_instr(1, 5'b01110, 1'b0, 1'b1);
        do_instr(1, 5'b10010, 1'b0, 1'b0);
        do_instr(1, 5'b10010, 1'b1, 1'b0);
        for (int n = 0; n < 30; n++) begin
            rop = 5'($urandom_range(0, 31));
            do_instr(1, rop, 1'($urandom), (rop != 5'b11010) && ($urandom_range(0, 7) == 0));
        end
        run_s[1] = 1'b0;

        // Reset asserted in the middle of the fetch wait
        ir_s[1] = {5'b00000, 27'd0};
        chk(1, PCEN | MARWE | ZWE | alu(INC_C), "pre_rst_f0");
        @(negedge clk);
        @(negedge clk);
        chk(1, RD | MDRWE, "pre_rst_f1w");
        @(negedge clk);
        chk(1, RD | MDRWE, "pre_rst_f1w2");
        reset = 1'b0;
        #1;
        chk(1, '0, "rst_async"); chk(0, '0, "rst_async");
        #1;
        reset = 1'b1;
        run_s[1] = 1'b1;
        @(negedge clk);
        chk(1, PCEN | MARWE | ZWE | alu(INC_C), "rst_release");
        chk(0, '0, "rst_other_idle");
        do_instr(1, 5'b00000, 1'b0, 1'b0);
        do_instr(1, 5'b00011, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
